regbank_dump_ctrl: RTL and testbench

Debug-side sequencer that walks every register of the register bank and streams each register's contents as bytes to the debug/UART transmit path. It owns one read port of the register bank while a dump is running. It is started by the debug unit only while the pipeline is halted. Bytes leave through a valid/ready handshake.

---
 rtl/regbank_dump_ctrl_if.sv | 32 +++
 rtl/regbank_dump_ctrl.sv | 148 ++++++++++++++
 tb/tb_regbank_dump_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regbank_dump_ctrl_if.sv
// Register-bank read port and byte-transmit handshake between the dump sequencer
// and its host.
interface regbank_dump_ctrl_if #(
    parameter int unsigned NB_DATA    = 32,
    parameter int unsigned NB_ADDRESS = 5,
    parameter int unsigned NB_BYTE    = 8
);
    logic [NB_ADDRESS-1:0] r_addr;
    logic                  r_en;
    logic [NB_DATA-1:0]    r_data;
    logic [NB_BYTE-1:0]    tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output r_addr,
        output r_en,
        output tx_data,
        output tx_valid,
        input  r_data,
        input  tx_ready
    );

    modport slave (
        input  r_addr,
        input  r_en,
        input  tx_data,
        input  tx_valid,
        output r_data,
        output tx_ready
    );
endinterface

// File: rtl/regbank_dump_ctrl.sv
// Walks every register of the bank and streams its contents MSB byte first over a
// valid/ready port. Define REGDUMP_CHECKSUM_EN to append an XOR checksum byte.
module regbank_dump_ctrl #(
    parameter int unsigned NB_DATA     = 32,
    parameter int unsigned NB_ADDRESS  = 5,
    parameter int unsigned N_REGISTERS = 32,
    parameter int unsigned NB_BYTE     = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_pipe_halted,
    regbank_dump_ctrl_if.master bus,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned NBytes = NB_DATA / NB_BYTE;
    localparam int unsigned NbCnt  = (NBytes > 1) ? $clog2(NBytes) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StSend,
`ifdef REGDUMP_CHECKSUM_EN
        StChk,
`endif
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [NB_ADDRESS-1:0] idx_q, idx_d;
    logic [NbCnt-1:0]      cnt_q, cnt_d;
    logic [NB_DATA-1:0]    shift_q, shift_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0]    acc_q, acc_d;
`endif

    logic                  r_en;
    logic                  tx_valid;
    logic [NB_BYTE-1:0]    tx_data;
    logic [NB_BYTE-1:0]    tx_byte;
    logic                  last_byte;
    logic                  last_reg;

    assign tx_byte   = shift_q[NB_DATA-1 -: NB_BYTE];
    assign last_byte = (cnt_q == NbCnt'(NBytes - 1));
    assign last_reg  = (idx_q == NB_ADDRESS'(N_REGISTERS - 1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
`ifdef REGDUMP_CHECKSUM_EN
        acc_d    = acc_q;
`endif
        r_en     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        o_done   = 1'b0;
        o_busy   = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (i_start && i_pipe_halted) begin
                    idx_d   = '0;
`ifdef REGDUMP_CHECKSUM_EN
                    acc_d   = '0;
`endif
                    state_d = StRead;
                end
            end
            StRead: begin
                r_en    = 1'b1;
                shift_d = bus.r_data;
                cnt_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                tx_valid = 1'b1;
                tx_data  = tx_byte;
                if (bus.tx_ready) begin
                    shift_d = shift_q << NB_BYTE;
                    cnt_d   = cnt_q + NbCnt'(1);
`ifdef REGDUMP_CHECKSUM_EN
                    acc_d   = acc_q ^ tx_byte;
`endif
                    if (last_byte) begin
                        if (!last_reg) begin
                            idx_d   = idx_q + NB_ADDRESS'(1);
                            state_d = StRead;
                        end else begin
`ifdef REGDUMP_CHECKSUM_EN
                            state_d = StChk;
`else
                            state_d = StDone;
`endif
                        end
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            StChk: begin
                tx_valid = 1'b1;
                tx_data  = acc_q;
                if (bus.tx_ready) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                o_done  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    // The index only moves on entry to a read, so it doubles as the held read address.
    assign bus.r_addr   = idx_q;
    assign bus.r_en     = r_en;
    assign bus.tx_valid = tx_valid;
    assign bus.tx_data  = tx_data;

endmodule

// File: tb/tb_regbank_dump_ctrl.sv
// Self-checking bench for regbank_dump_ctrl: builds the expected byte stream and
// timing from the register contents and compares the observed handshake traffic.
module tb_regbank_dump_ctrl;

    localparam int NbData  = 32;
    localparam int NbAddr  = 5;
    localparam int NRegs   = 32;
    localparam int NbByte  = 8;
    localparam int NBytes  = NbData / NbByte;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int ChkBytes = 1;
`else
    localparam int ChkBytes = 0;
`endif
    localparam int ExpDone = 1 + NRegs * (1 + NBytes) + ChkBytes;
    localparam int LastRead = 1 + (NRegs - 1) * (1 + NBytes);

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic halted;
    logic tx_ready;
    logic busy;
    logic done;

    logic [NbData-1:0] regs [NRegs];

    always #5 clk = ~clk;

    regbank_dump_ctrl_if #(.NB_DATA(NbData), .NB_ADDRESS(NbAddr), .NB_BYTE(NbByte)) bus ();

    assign bus.r_data   = regs[bus.r_addr];
    assign bus.tx_ready = tx_ready;

    regbank_dump_ctrl #(
        .NB_DATA    (NbData),
        .NB_ADDRESS (NbAddr),
        .N_REGISTERS(NRegs),
        .NB_BYTE    (NbByte)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_start      (start),
        .i_pipe_halted(halted),
        .bus          (bus),
        .o_busy       (busy),
        .o_done       (done)
    );

    int checks   = 0;
    int failures = 0;

    logic [NbByte-1:0] exp_q [$];
    logic [NbByte-1:0] got_q [$];

    int res_done_cyc;
    int res_busy_drop;
    int res_done_cnt;
    int res_ren_bad;
    int res_stab_bad;
    int res_last_xfer;
    bit res_aborted;

    // Expected stream: every register MSB byte first, then the XOR of all bytes.
    function automatic void build_model();
        logic [NbByte-1:0] x;
        x = '0;
        exp_q.delete();
        for (int k = 0; k < NRegs; k++) begin
            for (int b = 0; b < NBytes; b++) begin
                logic [NbByte-1:0] by;
                by = NbByte'(regs[k] >> (NbData - NbByte * (b + 1)));
                exp_q.push_back(by);
                x = x ^ by;
            end
        end
        if (ChkBytes == 1) exp_q.push_back(x);
    endfunction

    task automatic run_dump(input int stall_lo, input int stall_hi, input int rand_pct,
                            input int restart_cyc, input int abort_byte);
        bit               prev_stall;
        logic [NbByte-1:0] prev_data;
        bit               ren_check;
        logic             exp_ren;
        got_q.delete();
        res_done_cyc  = -1;
        res_busy_drop = -1;
        res_done_cnt  = 0;
        res_ren_bad   = 0;
        res_stab_bad  = 0;
        res_last_xfer = -1;
        res_aborted   = 1'b0;
        prev_stall    = 1'b0;
        prev_data     = '0;
        ren_check     = (stall_lo < 0) && (rand_pct == 0);
        @(negedge clk);
        halted   = 1'b1;
        start    = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 800; c++) begin
            @(negedge clk);
            start = (c == restart_cyc);
            if (rand_pct > 0) tx_ready = ($urandom_range(99) >= rand_pct);
            else tx_ready = !(c >= stall_lo && c <= stall_hi);
            if (prev_stall && (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data))
                res_stab_bad++;
            exp_ren = ((c - 1) % (1 + NBytes) == 0) && (c <= LastRead);
            if (ren_check && bus.r_en !== exp_ren) res_ren_bad++;
            if (abort_byte >= 0 && bus.tx_valid === 1'b1 && got_q.size() == abort_byte) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if ({bus.r_addr, bus.r_en, bus.tx_data, bus.tx_valid, busy, done} !== '0) begin
                    failures++;
                    $display("FAIL reset_async_outputs: addr=%0h en=%b data=%0h valid=%b busy=%b done=%b, required all 0",
                             bus.r_addr, bus.r_en, bus.tx_data, bus.tx_valid, busy, done);
                end
                res_aborted = 1'b1;
                break;
            end
            if (bus.tx_valid === 1'b1 && tx_ready) begin
                got_q.push_back(bus.tx_data);
                res_last_xfer = c;
            end
            prev_stall = (bus.tx_valid === 1'b1) && !tx_ready;
            prev_data  = bus.tx_data;
            if (done === 1'b1) begin
                res_done_cnt++;
                if (res_done_cyc < 0) res_done_cyc = c;
            end
            if (busy === 1'b0 && res_done_cyc >= 0) begin
                res_busy_drop = c;
                break;
            end
        end
        start    = 1'b0;
        tx_ready = 1'b1;
    endtask

    task automatic compare_stream(input string name);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_count: got %0d bytes, required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size()) begin
                failures++;
                $display("FAIL %s_byte%0d: missing, required %0h", name, i, exp_q[i]);
            end else if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_byte%0d: got %0h, required %0h", name, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic check_timing(input string name, input int exp_done);
        checks++;
        if (res_done_cyc != exp_done) begin
            failures++;
            $display("FAIL %s_done_cycle: got %0d, required %0d", name, res_done_cyc, exp_done);
        end
        checks++;
        if (res_done_cnt != 1) begin
            failures++;
            $display("FAIL %s_done_pulses: got %0d, required 1", name, res_done_cnt);
        end
        checks++;
        if (res_busy_drop != exp_done + 1) begin
            failures++;
            $display("FAIL %s_busy_drop: got %0d, required %0d", name, res_busy_drop, exp_done + 1);
        end
    endtask

    task automatic load_pattern();
        for (int k = 0; k < NRegs; k++) regs[k] = 32'hA0B0C000 + NbData'(k);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.r_addr, bus.r_en, bus.tx_data, bus.tx_valid, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: addr=%0h en=%b data=%0h valid=%b busy=%b done=%b, required all 0",
                     bus.r_addr, bus.r_en, bus.tx_data, bus.tx_valid, busy, done);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b valid=%b, required 0 0", busy, bus.tx_valid);
        end
    endtask

    task automatic test_full_dump();
        logic [NbByte-1:0] head [4];
        logic [NbByte-1:0] tail [4];
        head = '{8'hA0, 8'hB0, 8'hC0, 8'h00};
        tail = '{8'hA0, 8'hB0, 8'hC0, 8'h1F};
        load_pattern();
        build_model();
        run_dump(-1, -1, 0, 0, -1);
        compare_stream("full");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q.size() < NRegs * NBytes || got_q[i] !== head[i] ||
                got_q[NRegs * NBytes - 4 + i] !== tail[i]) begin
                failures++;
                $display("FAIL full_head_tail%0d: stream too short or wrong, required %0h / %0h",
                         i, head[i], tail[i]);
            end
        end
        checks++;
        if (res_ren_bad != 0) begin
            failures++;
            $display("FAIL full_r_en_pattern: %0d bad cycles, required 0", res_ren_bad);
        end
        check_timing("full", ExpDone);
    endtask

    task automatic test_backpressure();
        load_pattern();
        build_model();
        run_dump(3, 5, 0, 0, -1);
        compare_stream("bp");
        checks++;
        if (res_stab_bad != 0) begin
            failures++;
            $display("FAIL bp_stall_stable: %0d unstable cycles, required 0", res_stab_bad);
        end
        check_timing("bp", ExpDone + 3);
    endtask

    task automatic test_start_gating();
        @(negedge clk);
        halted = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (busy !== 1'b0 || bus.r_en !== 1'b0) begin
                failures++;
                $display("FAIL gate_unhalted: busy=%b r_en=%b, required 0 0", busy, bus.r_en);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        load_pattern();
        build_model();
        run_dump(-1, -1, 0, 40, -1);
        compare_stream("restart");
        check_timing("restart", ExpDone);
    endtask

    task automatic test_reset_mid();
        load_pattern();
        build_model();
        run_dump(-1, -1, 0, 0, 49);
        checks++;
        if (!res_aborted) begin
            failures++;
            $display("FAIL midreset_reached: aborted=%b, required 1", res_aborted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_dump(-1, -1, 0, 0, -1);
        checks++;
        if (got_q.size() == 0 || got_q[0] !== 8'hA0) begin
            failures++;
            $display("FAIL midreset_first_byte: size=%0d, required first byte a0", got_q.size());
        end
        compare_stream("midreset");
        check_timing("midreset", ExpDone);
    endtask

    task automatic test_checksum();
        logic [NbByte-1:0] last_exp;
        for (int k = 0; k < NRegs; k++) regs[k] = '0;
        regs[5] = 32'h12345678;
        build_model();
        last_exp = (ChkBytes == 1) ? 8'h08 : 8'h00;
        run_dump(-1, -1, 0, 0, -1);
        compare_stream("chk");
        checks++;
        if (got_q.size() != NRegs * NBytes + ChkBytes || got_q[got_q.size() - 1] !== last_exp) begin
            failures++;
            $display("FAIL chk_last_byte: size=%0d, required size %0d ending %0h",
                     got_q.size(), NRegs * NBytes + ChkBytes, last_exp);
        end
        check_timing("chk", ExpDone);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NRegs; k++) regs[k] = $urandom;
            build_model();
            run_dump(-1, -1, 35, 0, -1);
            compare_stream("rand");
            checks++;
            if (res_stab_bad != 0) begin
                failures++;
                $display("FAIL rand_stall_stable: %0d unstable cycles, required 0", res_stab_bad);
            end
            check_timing("rand", res_last_xfer + 1);
        end
    endtask

    initial begin
        start    = 1'b0;
        halted   = 1'b0;
        tx_ready = 1'b1;
        for (int k = 0; k < NRegs; k++) regs[k] = '0;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_gating();
        test_back_to_back();
        test_reset_mid();
        test_checksum();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
